// File: rtl/des_pkg.sv
// Shared DES constants for the iterative core: permutation tables, S-boxes,
// key shift schedules, FSM state type and small permutation helpers.
package des_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        HOLD
    } des_state_t;

    // Table entries use DES 1-based bit numbering; vectors are [0:N-1] so entry k maps to index k-1.
    localparam int IP_TABLE [0:63] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int FP_TABLE [0:63] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_TABLE [0:47] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_TABLE [0:31] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_TABLE [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TABLE [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Each box is stored row-major: index = row*16 + column.
    localparam int SBOX [0:7][0:63] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    // Decryption walks the key schedule backwards, so its shifts are the
    // encryption shifts reversed and offset by one round.
    localparam int LEFT_SHIFTS  [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int RIGHT_SHIFTS [0:15] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [0:63] initialPerm(input logic [0:63] x);
        logic [0:63] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[i] = x[IP_TABLE[i] - 1];
        return y;
    endfunction

    function automatic logic [0:63] finalPerm(input logic [0:63] x);
        logic [0:63] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[i] = x[FP_TABLE[i] - 1];
        return y;
    endfunction

    function automatic logic [0:47] expand(input logic [0:31] x);
        logic [0:47] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[i] = x[E_TABLE[i] - 1];
        return y;
    endfunction

    function automatic logic [0:31] feistelPerm(input logic [0:31] x);
        logic [0:31] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[i] = x[P_TABLE[i] - 1];
        return y;
    endfunction

    function automatic logic [0:55] permChoice1(input logic [0:63] x);
        logic [0:55] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[i] = x[PC1_TABLE[i] - 1];
        return y;
    endfunction

    function automatic logic [0:47] permChoice2(input logic [0:55] x);
        logic [0:47] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[i] = x[PC2_TABLE[i] - 1];
        return y;
    endfunction

    // Outer bits select the row, inner four bits the column.
    function automatic logic [3:0] sboxLookup(input int box, input logic [0:5] b);
        logic [5:0] idx;
        idx = {b[0], b[5], b[1], b[2], b[3], b[4]};
        return 4'(SBOX[box][idx]);
    endfunction

    function automatic logic [0:27] rotl28(input logic [0:27] x, input int n);
        return (x << n) | (x >> (28 - n));
    endfunction

    function automatic logic [0:27] rotr28(input logic [0:27] x, input int n);
        return (x >> n) | (x << (28 - n));
    endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: E expansion, subkey mix, S-boxes, P,
// then the L/R swap-and-xor.
module des_round
    import des_pkg::*;
(
    input  logic [0:31] l,
    input  logic [0:31] r,
    input  logic [0:47] subkey,
    output logic [0:31] nextL,
    output logic [0:31] nextR
);

    logic [0:47] mixed;
    logic [0:31] sboxOut;
    logic [0:31] fOut;

    always_comb begin
        mixed   = expand(r) ^ subkey;
        sboxOut = '0;
        for (int i = 0; i < 8; i++) begin
            sboxOut[4*i +: 4] = sboxLookup(i, mixed[6*i +: 6]);
        end
        fOut  = feistelPerm(sboxOut);
        nextL = r;
        nextR = l ^ fOut;
    end

endmodule

// File: rtl/des_encrypt_iter.sv
// Iterative DES core, one Feistel round per clock with a valid/ready handshake.
// Define DES_DUAL_MODE_EN to add a decrypt input that runs the key schedule in reverse.
module des_encrypt_iter
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:63] plainText,
    input  logic [0:63] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] cipherText
`ifdef DES_DUAL_MODE_EN
   ,input  logic        decrypt
`endif
);

    des_state_t  state;
    logic [3:0]  roundCount;
    logic [0:31] dataL;
    logic [0:31] dataR;
    logic [0:27] keyC;
    logic [0:27] keyD;
    logic [0:27] nextC;
    logic [0:27] nextD;
    logic [0:47] subkey;
    logic [0:31] roundL;
    logic [0:31] roundR;
`ifdef DES_DUAL_MODE_EN
    logic        decryptMode;
`endif

    // Subkey for the current round comes from the already-rotated C/D halves.
    always_comb begin
        nextC = rotl28(keyC, LEFT_SHIFTS[roundCount]);
        nextD = rotl28(keyD, LEFT_SHIFTS[roundCount]);
`ifdef DES_DUAL_MODE_EN
        if (decryptMode) begin
            nextC = rotr28(keyC, RIGHT_SHIFTS[roundCount]);
            nextD = rotr28(keyD, RIGHT_SHIFTS[roundCount]);
        end
`endif
        subkey = permChoice2({nextC, nextD});
    end

    des_round u_round (
        .l      (dataL),
        .r      (dataR),
        .subkey (subkey),
        .nextL  (roundL),
        .nextR  (roundR)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            roundCount <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            cipherText <= '0;
            dataL      <= '0;
            dataR      <= '0;
            keyC       <= '0;
            keyD       <= '0;
`ifdef DES_DUAL_MODE_EN
            decryptMode <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        {dataL, dataR} <= initialPerm(plainText);
                        {keyC, keyD}   <= permChoice1(key);
                        roundCount     <= '0;
                        in_ready       <= 1'b0;
                        state          <= ROUND;
`ifdef DES_DUAL_MODE_EN
                        decryptMode    <= decrypt;
`endif
                    end
                end
                ROUND: begin
                    dataL      <= roundL;
                    dataR      <= roundR;
                    keyC       <= nextC;
                    keyD       <= nextD;
                    roundCount <= roundCount + 4'd1;
                    if (roundCount == 4'd15) state <= FINAL;
                end
                // The last round's swap is undone here by presenting R16 before L16.
                FINAL: begin
                    cipherText <= finalPerm({dataR, dataL});
                    out_valid  <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_encrypt_iter.sv
// Directed bench for des_encrypt_iter using known DES vectors and a result queue.
// With DES_DUAL_MODE_EN defined it also exercises the decrypt input.
module tb_des_encrypt_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [0:63] plainText;
    logic [0:63] key;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] cipherText;
`ifdef DES_DUAL_MODE_EN
    logic        decrypt;
`endif

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    logic [0:63] expQ [$];

    des_encrypt_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plainText  (plainText),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cipherText (cipherText)
`ifdef DES_DUAL_MODE_EN
       ,.decrypt    (decrypt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Waits for in_ready, offers one block, returns just after the accepting edge.
    task automatic applyStimulus(input logic [0:63] pt, input logic [0:63] k, input bit dec,
                                 input logic [0:63] expected);
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        checkValue("accept_wait_in_ready", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        plainText = pt;
        key       = k;
`ifdef DES_DUAL_MODE_EN
        decrypt   = dec;
`else
        if (dec) $display("[TB] decrypt requested but dual mode is not built");
`endif
        expQ.push_back(expected);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        plainText = {$urandom, $urandom};
        key       = {$urandom, $urandom};
    endtask

    // Waits for out_valid, checks latency/result, optionally stalls the consumer.
    task automatic checkOutput(input string tag, input int holdCycles);
        int          lat;
        bit          seen;
        logic [0:63] expected;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) seen = 1'b1;
        end
        checkValue({tag, "_out_valid_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            expected = (expQ.size() > 0) ? expQ.pop_front() : 64'hx;
            checkValue({tag, "_latency"}, 64'(lat), 64'd18);
            checkValue({tag, "_cipher"}, cipherText, expected);
            checkValue({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
            for (int i = 0; i < holdCycles; i++) begin
                in_valid  = (i % 2 == 0);
                plainText = {$urandom, $urandom};
                key       = {$urandom, $urandom};
                @(negedge clk);
                checkValue({tag, "_hold_out_valid"}, 64'(out_valid), 64'd1);
                checkValue({tag, "_hold_cipher"}, cipherText, expected);
                checkValue({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
            end
            if (holdCycles > 0) in_valid = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            checkValue({tag, "_release_out_valid"}, 64'(out_valid), 64'd0);
            checkValue({tag, "_release_in_ready"}, 64'(in_ready), 64'd1);
            checkValue({tag, "_release_cipher_held"}, cipherText, expected);
        end
    endtask

    initial begin
        int acceptA;
        int acceptB;
        bit acceptedB;

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        plainText = 64'h0123456789ABCDEF;
        key       = 64'h133457799BBCDFF1;
`ifdef DES_DUAL_MODE_EN
        decrypt   = 1'b0;
`endif

        // Reset must win over a simultaneous in_valid.
        repeat (3) @(posedge clk);
        #1;
        checkValue("reset_in_ready", 64'(in_ready), 64'd1);
        checkValue("reset_out_valid", 64'(out_valid), 64'd0);
        checkValue("reset_cipher", cipherText, 64'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        $display("[TB] known-answer vectors");
        applyStimulus(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405);
        checkOutput("kat_classic", 0);
        applyStimulus(64'h8787878787878787, 64'h0E329232EA6D0D73, 1'b0, 64'h0000000000000000);
        checkOutput("kat_zero_out", 0);
        applyStimulus(64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7);
        checkOutput("kat_all_zero", 0);
        applyStimulus(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h7359B2163E4EDC58);
        checkOutput("kat_all_ones", 0);
        applyStimulus(64'h4E6F772069732074, 64'h0123456789ABCDEF, 1'b0, 64'h3FA40E8A984D4815);
        checkOutput("kat_now_is_t", 0);
        applyStimulus(64'h0123456789ABCDEF, 64'h123556789ABDDEF0, 1'b0, 64'h85E813540F0AB405);
        checkOutput("kat_parity_flipped", 0);

        $display("[TB] consumer stall with ignored in_valid pulses");
        out_ready = 1'b0;
        applyStimulus(64'h8787878787878787, 64'h0E329232EA6D0D73, 1'b0, 64'h0000000000000000);
        checkOutput("stall", 10);
        @(negedge clk);
        checkValue("stall_no_accept_in_ready", 64'(in_ready), 64'd1);
        checkValue("stall_no_accept_out_valid", 64'(out_valid), 64'd0);

        $display("[TB] reset in the middle of a block");
        applyStimulus(64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7);
        expQ.delete();
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkValue("abort_out_valid", 64'(out_valid), 64'd0);
        checkValue("abort_in_ready", 64'(in_ready), 64'd1);
        checkValue("abort_cipher", cipherText, 64'h0);
        rst_n = 1'b1;
        applyStimulus(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405);
        checkOutput("after_abort", 0);

        $display("[TB] back-to-back blocks");
        @(negedge clk);
        in_valid  = 1'b1;
        plainText = 64'h0123456789ABCDEF;
        key       = 64'h133457799BBCDFF1;
        expQ.push_back(64'h85E813540F0AB405);
        @(posedge clk);
        #1;
        acceptA   = cycleCount;
        plainText = 64'h4E6F772069732074;
        key       = 64'h0123456789ABCDEF;
        expQ.push_back(64'h3FA40E8A984D4815);
        checkOutput("b2b_first", 0);
        acceptedB = 1'b0;
        acceptB   = 0;
        for (int i = 0; i < 30 && !acceptedB; i++) begin
            @(posedge clk);
            #1;
            if (!in_ready) begin
                acceptedB = 1'b1;
                acceptB   = cycleCount;
            end
        end
        in_valid  = 1'b0;
        plainText = {$urandom, $urandom};
        key       = {$urandom, $urandom};
        checkValue("b2b_second_accepted", 64'(acceptedB), 64'd1);
        checkValue("b2b_accept_spacing", 64'(acceptB - acceptA), 64'd19);
        checkOutput("b2b_second", 0);

`ifdef DES_DUAL_MODE_EN
        $display("[TB] decrypt mode");
        applyStimulus(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1, 64'h0123456789ABCDEF);
        checkOutput("decrypt_classic", 0);
        applyStimulus(64'h3FA40E8A984D4815, 64'h0123456789ABCDEF, 1'b1, 64'h4E6F772069732074);
        checkOutput("decrypt_now_is_t", 0);
        applyStimulus(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405);
        checkOutput("encrypt_after_decrypt", 0);
`endif

        checkValue("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_encrypt_iter.md
DES_ENCRYPT_ITER -- requirements
Module: des_encrypt_iter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port in_valid  input  1  request to start one block.
REQ-004 SHALL have port in_ready  output  1  core idle, able to accept a block.
REQ-005 SHALL have port plainText  input  [0:63]  plaintext; bit 0 is DES bit 1 (MSB-first numbering).
REQ-006 SHALL have port key  input  [0:63]  64-bit key incl. parity bits 7,15,...,63, which are ignored.
REQ-007 SHALL have port out_valid  output  1  cipherText valid.
REQ-008 SHALL have port out_ready  input  1  consumer accepts cipherText.
REQ-009 SHALL have port cipherText  output  [0:63]  encrypted block, same numbering as plainText.

Function
REQ-010 SHALL implement FIPS 46-3 DES encryption, one Feistel round per clock.
REQ-011 SHALL use FSM states IDLE, ROUND, FINAL, HOLD.
REQ-012 IDLE: in_ready=1; on in_valid=1, SHALL register IP(plainText) into L/R and PC-1(key) into C/D, clear round counter, go to ROUND.
REQ-013 ROUND: per cycle, C/D SHALL rotate left by 1 in rounds 1,2,9,16 and by 2 otherwise, K=PC-2(C,D), L<=R, R<=L xor f(R,K); 4-bit counter increments.
REQ-014 After round 16 (counter=15), SHALL go to FINAL; FINAL SHALL register cipherText=FP(R16,L16) (swap before FP) and go to HOLD.
REQ-015 HOLD: out_valid=1, cipherText stable; on out_ready=1, SHALL return to IDLE next cycle.
REQ-016 Latency: out_valid SHALL rise 18 cycles after the edge sampling in_valid=1 with in_ready=1.
REQ-017 in_valid while in_ready=0 SHALL be ignored; plainText/key SHALL be sampled only at acceptance.
REQ-018 in_ready SHALL be 0 in ROUND, FINAL, HOLD; no input buffering, no overlap of blocks.
REQ-019 cipherText SHALL hold its last value after out_valid falls until the next FINAL.

Reset
REQ-020 rst_n=0 at a clock edge SHALL force IDLE, counter=0, out_valid=0, in_ready=1, cipherText=64'h0, L/R/C/D=0.
REQ-021 Reset mid-operation (any state) SHALL abort the block; no out_valid for it.
REQ-022 rst_n=0 SHALL override simultaneous in_valid/out_ready.

Configuration
REQ-023 Macro DES_DUAL_MODE_EN defined: SHALL add input port decrypt (1 bit, sampled at acceptance); decrypt=1 uses subkeys K16..K1 (C/D rotate right by 0 in round 1, 1 in rounds 2,9,16, 2 otherwise).
REQ-024 Macro undefined: no decrypt port; encryption only; behaviour per REQ-013.

Structure
REQ-025 Package des_pkg SHALL hold IP, FP, E, P, PC-1, PC-2, eight S-box tables, shift schedule constant, FSM state typedef.
REQ-026 Sub-module des_round (combinational: E, key xor, S-boxes, P, Feistel xor) SHALL be instantiated once.
REQ-027 No other sub-modules; target 120-400 lines RTL excluding package.

Verification
REQ-028 key=133457799BBCDFF1, plainText=0123456789ABCDEF -> cipherText=85E813540F0AB405, out_valid 18 cycles after accept.
REQ-029 key=0E329232EA6D0D73, plainText=8787878787878787 -> cipherText=0000000000000000.
REQ-030 Hold out_ready=0 for 10 cycles after out_valid -> cipherText/out_valid stable, in_ready=0; in_valid pulses ignored.
REQ-031 rst_n=0 in round 8, then new block REQ-028 -> only correct 85E813540F0AB405 appears, no spurious out_valid.
REQ-032 Back-to-back blocks with out_ready=1 always -> accept every 19 cycles, both results correct.
REQ-033 DES_DUAL_MODE_EN, decrypt=1, key=133457799BBCDFF1, plainText=85E813540F0AB405 -> cipherText=0123456789ABCDEF.
